mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor memory request protocol. It accepts single-cycle read/write requests from a processor's memory interface unit, holds one request in flight for a fixed access latency, commits writes to or fetches reads from a local word array, and returns a one-cycle response pulse with read data. It is the target end of the `read_req`/`write_req`/`addrout` channel and stands in for the memory subsystem in single-processor builds and benches.

## Interface
Parameters:
- `DATA_W`, 8: data word width.
- `ADDR_W`, 8: request address width.
- `DEPTH`, 64: array words; `DEPTH <= 2**ADDR_W`, power of two.
- `LATENCY`, 2: cycles from request acceptance to response; minimum 1.

Ports:
- `clk`, in, 1: the single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `read_req`, in, 1: read request, valid for one cycle.
- `write_req`, in, 1: write request, valid for one cycle.
- `addr`, in, ADDR_W: request address, sampled with the request.
- `write_data`, in, DATA_W: write word, sampled with `write_req`.
- `mem_resp`, out, 1: one-cycle completion pulse.
- `read_data`, out, DATA_W: read result, valid while `mem_resp` is high.
- `busy`, out, 1: high while a request is in flight and no new request can be accepted.
- `error`, out, 1: qualified by `mem_resp`; the completed access was invalid.
- `overrun`, out, 1: sticky; a request arrived while `busy`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `read_req|write_req`: latch op, `addr` and `write_data`; load `cnt = LATENCY-1`.
  - Go to WAIT if `LATENCY > 1`, otherwise go to RESP.
- **WAIT**
  - Decrement `cnt` each cycle.
  - When `cnt == 1`, go to RESP next cycle.
- **RESP**
  - `mem_resp = 1`.
  - For a read, `read_data` = array[latched addr].
  - For a write, the array is written on the RESP clock edge.
  - A request present in RESP is accepted with the same rules as in IDLE, giving back-to-back operation. With no request, go to IDLE.
- **Simultaneous `read_req` and `write_req`:** executed as a write; `error = 1` on its response.
- **Request while `busy`:** dropped; `overrun` set until reset.
- **Write then read of the same address back-to-back:** the read, accepted in the write's RESP cycle, returns the new data.
- **Reset mid-operation:** the in-flight request is aborted; a pending write is NOT committed.
- **Reset values:** state IDLE, `mem_resp = 0`, `read_data = 0`, `busy = 0`, `error = 0`, `overrun = 0`. Array contents are not reset.
- `read_data` is driven 0 whenever `mem_resp = 0`.

## Timing
- A request sampled at edge N produces `mem_resp` high in the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- `busy` is high in WAIT only. It is low in IDLE and RESP.
- Maximum throughput is one request per LATENCY cycles.
- `mem_resp` is exactly one cycle wide. There is no backpressure from the initiator; the initiator must capture data in the response cycle.

## Configuration
- `MEM_RESP_ADDR_CHECK_EN` defined:
  - A latched address `>= DEPTH` performs no array access.
  - The response still pulses at normal latency with `error = 1` and `read_data = 0`.
- Not defined:
  - The address is truncated to `$clog2(DEPTH)` bits, so accesses wrap.
  - `error` reflects only the simultaneous read/write case.

## Structure
- `tinyalu_pkg` holds:
  - the state enum `mem_resp_state_e` (IDLE, WAIT, RESP);
  - the default `DATA_W`/`ADDR_W` constants shared with the memory interface unit.
- Sub-module `mem_resp_array` holds the storage:
  - synchronous write port and combinational read port;
  - parameters `DATA_W` and `DEPTH`.
- The top level contains the FSM, latency counter, request latches and flags.

## Test plan
- **Write then read, LATENCY=2:** write 0xA5 to addr 3, then read addr 3 → `mem_resp` 2 cycles after each request; read returns 0xA5 with `error = 0`.
- **Back-to-back, LATENCY=1:** write 0x3C to addr 7 with a read of addr 7 issued in its RESP cycle → read responds the next cycle with 0x3C; `busy` never asserts.
- **Request while busy, LATENCY=4:** read issued one cycle after a prior read → second request dropped, `overrun = 1`, only one `mem_resp`.
- **Simultaneous requests:** `read_req` and `write_req` together with data 0x11 at addr 5 → write committed, response has `error = 1`; a subsequent read of 5 returns 0x11.
- **Reset mid-operation, LATENCY=3:** write 0xFF to addr 2 after addr 2 holds 0x22, `reset` asserted in WAIT → no `mem_resp`, all outputs 0; a later read of addr 2 returns 0x22.
- **Out of range, DEPTH=64:**
  - With `MEM_RESP_ADDR_CHECK_EN`, a read of addr 70 → `error = 1`, `read_data = 0`.
  - Without it, a read of addr 70 returns the contents of addr 6.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types and default widths for the processor memory request channel.
package tinyalu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, combinational read.
module mem_resp_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed access latency.
// Optional MEM_RESP_ADDR_CHECK_EN flags addresses >= DEPTH instead of wrapping them.
module mem_responder
  import tinyalu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_resp,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              error,
  output logic              overrun
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_resp_state_e   state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req, accept;
  logic              op_w, op_err, oob_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q, rdata;
  logic              oob, in_resp, we;

`ifdef MEM_RESP_ADDR_CHECK_EN
  assign oob = (addr >> IDX_W) != '0;
`else
  // Upper address bits are simply dropped so accesses wrap.
  logic addr_hi_unused;
  assign addr_hi_unused = |(addr >> IDX_W);
  assign oob = 1'b0;
`endif

  assign req = read_req | write_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_w    <= 1'b0;
      op_err  <= 1'b0;
      oob_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_w    <= write_req;
        op_err  <= read_req & write_req;
        oob_q   <= oob;
        idx_q   <= addr[IDX_W-1:0];
        wdata_q <= write_data;
      end
      if (state == WAIT && req) overrun <= 1'b1;
    end
  end

  assign in_resp = (state == RESP);
  // Gating with reset keeps an aborted write out of the array.
  assign we      = in_resp & op_w & ~oob_q & ~reset;

  mem_resp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign mem_resp  = in_resp;
  assign busy      = (state == WAIT);
  assign error     = in_resp & (op_err | oob_q);
  assign read_data = (in_resp & ~op_w & ~oob_q) ? rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Drives four responders (LATENCY 1..4) with shared stimulus and checks each
// against a transaction-level model: completion time, memory image, sticky overrun.
module tb_mem_responder;
  localparam int N = 4, DW = 8, AW = 8, DEPTH = 64;

  logic clk = 1'b0;
  logic reset, read_req, write_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [N-1:0]  resp_v, busy_v, err_v, ovr_v;
  logic [DW-1:0] rd_v [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(g + 1)) dut (
      .clk        (clk),
      .reset      (reset),
      .read_req   (read_req),
      .write_req  (write_req),
      .addr       (addr),
      .write_data (write_data),
      .mem_resp   (resp_v[g]),
      .read_data  (rd_v[g]),
      .busy       (busy_v[g]),
      .error      (err_v[g]),
      .overrun    (ovr_v[g])
    );
  end

`ifdef MEM_RESP_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int passed = 0, total = 0, cyc = 0;

  // reference model, one per instance
  bit      pend   [N];
  int      rc     [N];
  bit      op_w   [N];
  bit      op_err [N];
  int      op_a   [N];
  int      op_d   [N];
  bit      ovr    [N];
  int      mem    [N][DEPTH];
  bit      known  [N][DEPTH];
  logic [DW-1:0] last_rd [N];
  logic          last_err[N];

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d cyc %0d: got %0h expected %0h", tag, k, cyc, obs, exp);
  endtask

  task automatic cycle(bit rr, bit wr, int a, int d, bit rst);
    bit er [N];
    bit eb [N];
    for (int k = 0; k < N; k++) begin
      er[k] = pend[k] && cyc == rc[k];
      eb[k] = pend[k] && cyc < rc[k];
      chk("mem_resp", k, 32'(resp_v[k]), 32'(er[k]));
      chk("busy", k, 32'(busy_v[k]), 32'(eb[k]));
      chk("overrun", k, 32'(ovr_v[k]), 32'(ovr[k]));
      if (er[k]) begin
        bit bad;
        bad = CHK_EN && op_a[k] >= DEPTH;
        last_rd[k]  = rd_v[k];
        last_err[k] = err_v[k];
        chk("error", k, 32'(err_v[k]), 32'(op_err[k] || bad));
        if (!op_w[k]) begin
          if (bad) chk("read_data_oob", k, 32'(rd_v[k]), 0);
          else if (known[k][op_a[k] % DEPTH])
            chk("read_data", k, 32'(rd_v[k]), 32'(mem[k][op_a[k] % DEPTH]));
        end
      end else begin
        chk("read_data_idle", k, 32'(rd_v[k]), 0);
      end
    end
    reset = rst; read_req = rr; write_req = wr;
    addr = a[AW-1:0]; write_data = d[DW-1:0];
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        pend[k] = 0; ovr[k] = 0;
      end else begin
        if (er[k] && op_w[k] && !(CHK_EN && op_a[k] >= DEPTH)) begin
          mem[k][op_a[k] % DEPTH]   = op_d[k];
          known[k][op_a[k] % DEPTH] = 1;
        end
        if (er[k]) pend[k] = 0;
        if (rr || wr) begin
          if (eb[k]) ovr[k] = 1;
          else begin
            pend[k] = 1; rc[k] = cyc + k + 1;
            op_w[k] = wr; op_err[k] = rr && wr;
            op_a[k] = a; op_d[k] = d & 8'hFF;
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask
  task automatic wr_req(int a, int d); cycle(0, 1, a, d, 0); endtask
  task automatic rd_req(int a);        cycle(1, 0, a, 0, 0); endtask
  task automatic do_rst();             cycle(0, 0, 0, 0, 1); endtask

  initial begin
    reset = 1; read_req = 0; write_req = 0; addr = '0; write_data = '0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 0; ovr[k] = 0; rc[k] = 0;
      for (int i = 0; i < DEPTH; i++) known[k][i] = 0;
    end
    repeat (2) @(negedge clk);
    do_rst();

    // fill the array; 4-cycle spacing keeps every instance accepting
    for (int i = 0; i < DEPTH; i++) begin
      wr_req(i, (i * 3 + 1) & 8'hFF);
      idle(3);
    end
    idle(4);

    // write then read, LATENCY=2
    do_rst(); wr_req(3, 8'hA5); idle(3); rd_req(3); idle(4);
    chk("t1_rd", 1, 32'(last_rd[1]), 32'hA5);
    chk("t1_err", 1, 32'(last_err[1]), 0);

    // back-to-back write/read, LATENCY=1
    do_rst(); wr_req(7, 8'h3C); rd_req(7); idle(5);
    chk("t2_rd", 0, 32'(last_rd[0]), 32'h3C);

    // request while busy, LATENCY=4
    do_rst(); rd_req(10); rd_req(11); idle(5);
    chk("t3_ovr", 3, 32'(ovr_v[3]), 1);

    // simultaneous read+write
    do_rst(); cycle(1, 1, 5, 8'h11, 0); idle(4);
    for (int k = 0; k < N; k++) chk("t4_err", k, 32'(last_err[k]), 1);
    rd_req(5); idle(4);
    for (int k = 0; k < N; k++) chk("t4_rd", k, 32'(last_rd[k]), 32'h11);

    // reset in WAIT aborts the write, LATENCY=3
    do_rst(); wr_req(2, 8'h22); idle(4); wr_req(2, 8'hFF); idle(1); do_rst(); idle(2);
    rd_req(2); idle(4);
    chk("t5_rd", 2, 32'(last_rd[2]), 32'h22);

    // out of range address
    do_rst(); rd_req(70); idle(4);
`ifdef MEM_RESP_ADDR_CHECK_EN
    chk("t6_rd", 1, 32'(last_rd[1]), 0);
    chk("t6_err", 1, 32'(last_err[1]), 1);
`else
    chk("t6_rd", 1, 32'(last_rd[1]), 32'(6 * 3 + 1));
    chk("t6_err", 1, 32'(last_err[1]), 0);
`endif

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r, a, d;
      r = int'($urandom_range(0, 99));
      a = int'($urandom_range(0, 80));
      d = int'($urandom_range(0, 255));
      if (r < 2)       cycle(0, 0, a, d, 1);
      else if (r < 30) cycle(1, 0, a, d, 0);
      else if (r < 55) cycle(0, 1, a, d, 0);
      else if (r < 60) cycle(1, 1, a, d, 0);
      else             cycle(0, 0, a, d, 0);
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
